// File: rtl/instruction_memory_loadable.sv
// Instruction memory with little-endian byte-stream loader and registered, fault-checked fetch.
// Optional debug read port enabled by defining IMEM_DEBUG_READ_EN.
module instruction_memory_loadable #(
    parameter int              NB        = 32,
    parameter int              NB_BYTE   = 8,
    parameter int              DEPTH     = 256,
    parameter int              ADDR_W    = $clog2(DEPTH),
    parameter logic [NB-1:0]   HALT_WORD = 32'hFFFF_FFFF,
    parameter logic [NB-1:0]   NOP_WORD  = 32'h0000_0000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_step,
    input  logic [NB-1:0]      i_pc,
    output logic [NB-1:0]      o_instruction,
    output logic               o_misaligned,
    output logic               o_out_of_range,
    input  logic               i_load_start,
    input  logic               i_load_valid,
    input  logic [NB_BYTE-1:0] i_load_byte,
    output logic               o_load_ready,
    output logic               o_load_done,
    output logic               o_load_overflow,
    output logic [ADDR_W:0]    o_load_count,
`ifdef IMEM_DEBUG_READ_EN
    input  logic [ADDR_W-1:0]  i_dbg_addr,
    output logic [NB-1:0]      o_dbg_word,
`endif
    output logic               o_busy
);

    localparam int BYTES = NB / NB_BYTE;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [NB:0] PC_LIMIT = (NB+1)'(DEPTH * 4);

    typedef enum logic [1:0] {IDLE, LOADING, DONE} state_e;

    state_e              state_q, state_d;
    logic [BCW-1:0]      byte_cnt_q, byte_cnt_d;
    logic [NB-1:0]       asm_q, asm_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic [NB-1:0]       instr_q, instr_d;
    logic                mis_q, mis_d;
    logic                oor_q, oor_d;

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [NB-1:0]       word_next;

    // Power-up contents are zero in simulation; reset never clears the array.
    logic [NB-1:0]       mem [DEPTH] = '{default: '0};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        count_d    = count_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        instr_d    = instr_q;
        mis_d      = mis_q;
        oor_d      = oor_q;
        wr_en      = 1'b0;
        wr_addr    = count_q[ADDR_W-1:0];
        word_next  = asm_q;
        word_next[byte_cnt_q*NB_BYTE +: NB_BYTE] = i_load_byte;

        case (state_q)
            IDLE, DONE: begin
                if (i_load_start) begin
                    state_d    = LOADING;
                    byte_cnt_d = '0;
                    asm_d      = '0;
                    count_d    = '0;
                    done_d     = 1'b0;
                    ovf_d      = 1'b0;
                end
            end
            LOADING: begin
                // A start pulse wins over a byte arriving in the same cycle.
                if (i_load_start) begin
                    byte_cnt_d = '0;
                    asm_d      = '0;
                    count_d    = '0;
                end else if (i_load_valid && ready_q) begin
                    if (byte_cnt_q == BCW'(BYTES - 1)) begin
                        wr_en      = 1'b1;
                        count_d    = count_q + 1'b1;
                        byte_cnt_d = '0;
                        asm_d      = '0;
                        if (word_next == HALT_WORD) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else if (count_d == (ADDR_W+1)'(DEPTH)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            ovf_d   = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        asm_d      = word_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == LOADING);
        busy_d  = (state_d == LOADING);

        if (i_step && (state_q != LOADING)) begin
            if ({1'b0, i_pc} >= PC_LIMIT) begin
                instr_d = NOP_WORD;
                oor_d   = 1'b1;
                mis_d   = 1'b0;
            end else if (i_pc[1:0] != 2'b00) begin
                instr_d = NOP_WORD;
                oor_d   = 1'b0;
                mis_d   = 1'b1;
            end else begin
                instr_d = mem[i_pc[ADDR_W+1:2]];
                oor_d   = 1'b0;
                mis_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            instr_q    <= NOP_WORD;
            mis_q      <= 1'b0;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            count_q    <= count_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            instr_q    <= instr_d;
            mis_q      <= mis_d;
            oor_q      <= oor_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset && wr_en) begin
            mem[wr_addr] <= word_next;
        end
    end

`ifdef IMEM_DEBUG_READ_EN
    logic [NB-1:0] dbg_q;

    // Reads the pre-write contents when the loader targets the same word.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            dbg_q <= NOP_WORD;
        end else begin
            dbg_q <= mem[i_dbg_addr];
        end
    end

    assign o_dbg_word = dbg_q;
`endif

    assign o_instruction   = instr_q;
    assign o_misaligned    = mis_q;
    assign o_out_of_range  = oor_q;
    assign o_load_ready    = ready_q;
    assign o_load_done     = done_q;
    assign o_load_overflow = ovf_q;
    assign o_load_count    = count_q;
    assign o_busy          = busy_q;

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Directed bench for instruction_memory_loadable: default-depth instance plus a DEPTH=4 instance
// sharing stimulus. Debug-port checks are compiled in when IMEM_DEBUG_READ_EN is defined.
module tb_instruction_memory_loadable;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        step = 1'b0;
    logic [31:0] pc = '0;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = '0;
    logic [7:0]  dbg_addr = '0;
    logic [1:0]  dbg_addr_b = '0;

    logic [31:0] a_instr, b_instr;
    logic        a_mis, a_oor, a_ready, a_done, a_ovf, a_busy;
    logic        b_mis, b_oor, b_ready, b_done, b_ovf, b_busy;
    logic [8:0]  a_count;
    logic [2:0]  b_count;
`ifdef IMEM_DEBUG_READ_EN
    logic [31:0] a_dbg, b_dbg;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_memory_loadable dut_a (
        .i_clk(clk), .i_reset(rst_n), .i_step(step), .i_pc(pc),
        .o_instruction(a_instr), .o_misaligned(a_mis), .o_out_of_range(a_oor),
        .i_load_start(ld_start), .i_load_valid(ld_valid), .i_load_byte(ld_byte),
        .o_load_ready(a_ready), .o_load_done(a_done), .o_load_overflow(a_ovf),
        .o_load_count(a_count),
`ifdef IMEM_DEBUG_READ_EN
        .i_dbg_addr(dbg_addr), .o_dbg_word(a_dbg),
`endif
        .o_busy(a_busy)
    );

    instruction_memory_loadable #(.DEPTH(4)) dut_b (
        .i_clk(clk), .i_reset(rst_n), .i_step(step), .i_pc(pc),
        .o_instruction(b_instr), .o_misaligned(b_mis), .o_out_of_range(b_oor),
        .i_load_start(ld_start), .i_load_valid(ld_valid), .i_load_byte(ld_byte),
        .o_load_ready(b_ready), .o_load_done(b_done), .o_load_overflow(b_ovf),
        .o_load_count(b_count),
`ifdef IMEM_DEBUG_READ_EN
        .i_dbg_addr(dbg_addr_b), .o_dbg_word(b_dbg),
`endif
        .o_busy(b_busy)
    );

    typedef struct {
        logic        step;
        logic [31:0] pc;
        logic [31:0] exp_instr;
        logic        exp_mis;
        logic        exp_oor;
    } fetch_vec_t;

    fetch_vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        ld_valid = 1'b1;
        ld_byte  = b;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr);
        step = 1'b1;
        pc   = addr;
        tick();
        step = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'd0,    32'h1234_5678, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'd4,    32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'd8,    32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'd6,    32'h0000_0000, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 32'd4,    32'h0000_0000, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 32'd1024, 32'h0000_0000, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 32'd1027, 32'h0000_0000, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 32'd0,    32'h0000_0000, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 32'd2,    32'h0000_0000, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 32'd4,    32'hDEAD_BEEF, 1'b0, 1'b0};

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_instr", a_instr, 32'h0);
        chk("rst_ready", a_ready, 1'b0);
        chk("rst_done", a_done, 1'b0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_count", 32'(a_count), 32'd0);
        fetch(32'd0);
        chk("first_fetch_instr", a_instr, 32'h0);
        chk("first_fetch_mis", a_mis, 1'b0);
        chk("first_fetch_oor", a_oor, 1'b0);

        // Three-word image terminated by HALT
        pulse_start();
        chk("load_busy", a_busy, 1'b1);
        chk("load_ready", a_ready, 1'b1);
        foreach (vecs[i]) begin end
        begin
            logic [7:0] img [12] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE,
                                     8'hAD, 8'hDE, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
            for (int i = 0; i < 12; i++) begin
                send_byte(img[i]);
                if (i == 7) chk("count_after_2_words", 32'(a_count), 32'd2);
            end
        end
        chk("halt_done", a_done, 1'b1);
        chk("halt_count", 32'(a_count), 32'd3);
        chk("halt_ovf", a_ovf, 1'b0);
        chk("halt_ready", a_ready, 1'b0);
        chk("halt_busy", a_busy, 1'b0);
        send_byte(8'h55);
        chk("done_ignores_bytes", 32'(a_count), 32'd3);

        // Output must not move before the clock edge that samples the request
        step = 1'b1;
        pc   = 32'd0;
        #2;
        chk("latency_pre_edge", a_instr, 32'h0);

        for (int i = 0; i < 10; i++) begin
            step = vecs[i].step;
            pc   = vecs[i].pc;
            tick();
            chk($sformatf("vec%0d_instr", i), a_instr, vecs[i].exp_instr);
            chk($sformatf("vec%0d_mis", i), a_mis, vecs[i].exp_mis);
            chk($sformatf("vec%0d_oor", i), a_oor, vecs[i].exp_oor);
        end
        step = 1'b0;

        // Restart mid-word; fetch must stall while loading
        pulse_start();
        send_byte(8'hAA);
        step = 1'b1;
        pc   = 32'd0;
        send_byte(8'hBB);
        step = 1'b0;
        chk("fetch_blocked_loading", a_instr, 32'hDEAD_BEEF);
`ifdef IMEM_DEBUG_READ_EN
        dbg_addr = 8'd1;
        tick();
        chk("dbg_during_loading", a_dbg, 32'hDEAD_BEEF);
`endif
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_byte  = 8'hCC;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        chk("restart_count", 32'(a_count), 32'd0);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("restart_word_count", 32'(a_count), 32'd1);
        chk("restart_still_busy", a_busy, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'hFF);
        chk("restart_done", a_done, 1'b1);
        chk("restart_final_count", 32'(a_count), 32'd2);
        fetch(32'd0);
        chk("restart_word0", a_instr, 32'h4433_2211);
`ifdef IMEM_DEBUG_READ_EN
        tick();
        chk("dbg_after_reload", a_dbg, 32'hFFFF_FFFF);
`endif

        // Reset in the middle of a load
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h05);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_count", 32'(a_count), 32'd0);
        chk("midrst_busy", a_busy, 1'b0);
        chk("midrst_ready", a_ready, 1'b0);
        chk("midrst_done", a_done, 1'b0);
        chk("midrst_instr", a_instr, 32'h0);
        send_byte(8'h77);
        chk("idle_ignores_bytes", 32'(a_count), 32'd0);
        fetch(32'd0);
        chk("midrst_word0_kept", a_instr, 32'h0403_0201);
        fetch(32'd4);
        chk("midrst_word1_kept", a_instr, 32'hFFFF_FFFF);

        // DEPTH=4 instance: fill memory without a HALT
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        pulse_start();
        for (int i = 1; i <= 16; i++) begin
            send_byte(8'(i));
            if (i == 15) chk("b_ready_before_last", b_ready, 1'b1);
        end
        chk("b_ovf", b_ovf, 1'b1);
        chk("b_done", b_done, 1'b1);
        chk("b_count", 32'(b_count), 32'd4);
        chk("b_ready_after_full", b_ready, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'hFF);
        chk("b_extra_ignored", 32'(b_count), 32'd4);
        chk("b_ovf_sticky", b_ovf, 1'b1);
        fetch(32'd12);
        chk("b_word3", b_instr, 32'h100F_0E0D);
        fetch(32'd0);
        chk("b_word0", b_instr, 32'h0403_0201);
        fetch(32'd16);
        chk("b_oor_instr", b_instr, 32'h0);
        chk("b_oor_flag", b_oor, 1'b1);
`ifdef IMEM_DEBUG_READ_EN
        dbg_addr_b = 2'd1;
        tick();
        chk("b_dbg_word1", b_dbg, 32'h0807_0605);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_memory_loadable.md
Name: instruction_memory_loadable

Overview:
Parametrised instruction memory for the fetch stage with a built-in byte-stream loader.
- Program image arrives one byte at a time from the debug/UART unit, is assembled little-endian into words and written sequentially.
- Loading ends on a HALT sentinel or when memory is full.
- Fetch is word-aligned on a byte-addressed PC, gated by i_step, with 1-cycle registered latency and fault flags for bad PCs.

Parameters:
NB, 32, instruction word width (multiple of NB_BYTE)
NB_BYTE, 8, loader byte width
DEPTH, 256, memory depth in words (power of 2)
ADDR_W, $clog2(DEPTH), word-address width (derived, not overridden)
HALT_WORD, 32'hFFFF_FFFF, sentinel that terminates a load
NOP_WORD, 32'h0000_0000, word driven on reset and on faulted fetch

Ports:
i_clk  in  1  clock; all logic on rising edge
i_reset  in  1  synchronous, active-low reset
i_step  in  1  fetch enable; fetch outputs update only when high
i_pc  in  NB  byte-addressed program counter
o_instruction  out  NB  fetched instruction word
o_misaligned  out  1  last fetch had i_pc[1:0]!=0
o_out_of_range  out  1  last fetch had i_pc >= DEPTH*4
i_load_start  in  1  pulse: begin/restart a load at word 0
i_load_valid  in  1  loader byte valid
i_load_byte  in  NB_BYTE  loader byte
o_load_ready  out  1  loader can accept a byte this cycle
o_load_done  out  1  load finished (sticky until next start)
o_load_overflow  out  1  load ended by full memory, no HALT seen
o_load_count  out  ADDR_W+1  words written in current/last load
o_busy  out  1  high while in LOADING

Behaviour:
- Reset (i_reset==0 at clock edge):
  - State goes to IDLE.
  - o_instruction=NOP_WORD.
  - o_misaligned, o_out_of_range, o_load_ready, o_load_done, o_load_overflow, o_busy = 0.
  - o_load_count=0; byte counter and assembly register = 0.
  - Memory array contents are NOT cleared by reset; they are zero-initialised for simulation only.
  - Reset in mid-load aborts the load; words already written remain in memory.
- FSM states: IDLE, LOADING, DONE.
  - IDLE/DONE -> LOADING on i_load_start. Clears o_load_count, byte counter, o_load_done and o_load_overflow.
  - LOADING -> LOADING on i_load_start: restart at word 0 and discard any partial word.
  - i_load_start has priority over a same-cycle byte.
- LOADING:
  - o_load_ready=1 and o_busy=1.
  - A byte is accepted when i_load_valid && o_load_ready.
  - Byte k of a word (k=0..NB/NB_BYTE-1) lands in bits [k*NB_BYTE +: NB_BYTE], i.e. first byte is LSB.
  - On acceptance of the last byte, the full word is written to mem[o_load_count] in that clock and o_load_count increments.
  - If the written word == HALT_WORD, go to DONE with o_load_done=1. The HALT word is stored and counted.
  - Else if o_load_count reaches DEPTH, go to DONE with o_load_done=1 and o_load_overflow=1.
  - o_load_ready drops to 0 in the cycle the state becomes DONE.
- DONE: o_load_ready=0; bytes are ignored; flags hold until the next i_load_start.
- Fetch:
  - Active only when i_step=1 and state != LOADING.
  - Latency: outputs are registered 1 cycle after the sampled i_pc.
  - Word index = i_pc[ADDR_W+1:2].
  - Fault priority: out_of_range over misaligned.
    - i_pc >= DEPTH*4: o_instruction=NOP_WORD, o_out_of_range=1, o_misaligned=0.
    - Else if i_pc[1:0]!=0: o_instruction=NOP_WORD, o_misaligned=1.
    - Else: mem[index] is output with both flags 0.
  - i_step=0 or state==LOADING: all fetch outputs hold their previous values.
- No read/write collision is possible, because fetch is blocked while LOADING.

Optional Feature:
Macro: IMEM_DEBUG_READ_EN.
- Defined:
  - Adds ports i_dbg_addr (in, ADDR_W) and o_dbg_word (out, NB).
  - o_dbg_word <= mem[i_dbg_addr] every clock, 1-cycle latency, independent of state and i_step.
  - Reset value of o_dbg_word is NOP_WORD.
  - During a same-cycle write to the same address, o_dbg_word returns the old contents.
- Undefined: the ports are absent and no extra read port is inferred.

Test Plan:
- Reset, then i_step=1, i_pc=0 -> o_instruction=0, all flags 0, o_load_count=0.
- Load bytes 78,56,34,12,EF,BE,AD,DE,FF,FF,FF,FF -> o_load_done=1, o_load_count=3, o_load_overflow=0; fetch pc=0 gives 12345678, pc=4 gives DEADBEEF, pc=8 gives FFFFFFFF, each one cycle after the request.
- DEPTH=4, load 16 non-HALT bytes plus 4 extra -> o_load_overflow=1, o_load_count=4, o_load_ready=0 after the 16th byte, extra bytes ignored.
- Fetch pc=6 -> NOP_WORD, o_misaligned=1. Fetch pc=DEPTH*4 -> NOP_WORD, o_out_of_range=1. Fetch with i_step=0 -> outputs unchanged.
- Mid-load: after 2 bytes pulse i_load_start, then load 11,22,33,44 -> mem[0]=44332211; in a separate run, drive i_reset=0 after 5 bytes -> state IDLE, word 0 retained, o_load_count=0.
- With IMEM_DEBUG_READ_EN: i_dbg_addr=1 after the load in scenario 2 -> o_dbg_word=DEADBEEF next cycle, including during LOADING of a new image before word 1 is overwritten.
